// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and helpers
// for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // bits needed to count 0..w
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// full_sub: one-bit full subtractor cell,
// d = x - y - b_in with borrow-out.
module full_sub (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  // difference bit and borrow to next weight
  always_comb begin
    d     = x ^ y ^ b_in;
    b_out = (~x & y) | (~(x ^ y) & b_in);
  end

endmodule

// File: rtl/serial_sub.sv
// serial_sub: LSB-first bit-serial
// subtractor, one bit per clock.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             ovf
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sx;
  logic [WIDTH-1:0] sy;
  logic [WIDTH-1:0] acc;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             x_msb;
  logic             y_msb;

  logic             bit_d;
  logic             bit_b;
  logic [WIDTH-1:0] acc_nxt;

  full_sub u_fs (
    .x    (sx[0]),
    .y    (sy[0]),
    .b_in (brw),
    .d    (bit_d),
    .b_out(bit_b)
  );

  // new result bit enters at the MSB
  always_comb begin
    acc_nxt = {bit_d, acc[WIDTH-1:1]};
  end

  // control FSM plus serial datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      b_out <= 1'b0;
      ovf   <= 1'b0;
      sx    <= '0;
      sy    <= '0;
      acc   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      x_msb <= 1'b0;
      y_msb <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sx    <= x;
            sy    <= y;
            brw   <= b_in;
            x_msb <= x[WIDTH-1];
            y_msb <= y[WIDTH-1];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sx  <= sx >> 1;
          sy  <= sy >> 1;
          acc <= acc_nxt;
          brw <= bit_b;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            d     <= acc_nxt;
            b_out <= bit_b;
            ovf   <= (x_msb != y_msb) &
                     (bit_d != x_msb);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            sx    <= x;
            sy    <= y;
            brw   <= b_in;
            x_msb <= x[WIDTH-1];
            y_msb <= y[WIDTH-1];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: random/directed stimulus,
// queue scoreboard, arithmetic model.
module tb_serial_sub;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         o;
    logic [W-1:0] xa;
    logic [W-1:0] ya;
    logic         ba;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         b_out;
  logic         ovf;

  int checks;
  int failures;
  int cyc;
  exp_t sb[$];

  serial_sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .x    (x),
    .y    (y),
    .b_in (b_in),
    .busy (busy),
    .done (done),
    .d    (d),
    .b_out(b_out),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // plain-arithmetic reference
  function automatic exp_t model(
    input logic [W-1:0] a,
    input logic [W-1:0] bb,
    input logic         bi
  );
    exp_t e;
    int   r;
    int   u;
    r = int'($signed(a)) - int'($signed(bb))
        - int'(bi);
    u = int'(a) - int'(bb) - int'(bi);
    e.d  = u[W-1:0];
    e.b  = (u < 0);
    e.o  = (r < -(1 << (W - 1))) ||
           (r > (1 << (W - 1)) - 1);
    e.xa = a;
    e.ya = bb;
    e.ba = bi;
    return e;
  endfunction

  task automatic chk(
    input string nm,
    input int    act,
    input int    req
  );
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, req);
    end
  endtask

  // monitor: compare on every done pulse
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      chk("busy_at_done", int'(busy), 0);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got d=%0h want none",
                 d);
      end else begin
        e = sb.pop_front();
        if (d !== e.d || b_out !== e.b ||
            ovf !== e.o) begin
          failures++;
          $display("FAIL result x=%h y=%h b=%0d: got d=%h b=%0d o=%0d want d=%h b=%0d o=%0d",
                   e.xa, e.ya, e.ba, d, b_out, ovf,
                   e.d, e.b, e.o);
        end
      end
    end
  end

  // issue one op; optionally scramble inputs
  // while busy; check accept-to-done latency
  task automatic op(
    input logic [W-1:0] a,
    input logic [W-1:0] bb,
    input logic         bi,
    input bit           noise
  );
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    x     = a;
    y     = bb;
    b_in  = bi;
    sb.push_back(model(a, bb, bi));
    @(posedge clk);
    #1;
    start = 1'b0;
    n     = 1;
    seen  = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) begin
        start = 1'b0;
        seen  = 1;
        break;
      end
      if (noise) begin
        start = 1'($urandom);
        x     = W'($urandom);
        y     = W'($urandom);
        b_in  = 1'($urandom);
      end
      @(posedge clk);
      n++;
    end
    start = 1'b0;
    if (!seen)
      chk("done_timeout", 0, 1);
    else
      chk("latency", n, W + 1);
  endtask

  initial begin
    int last;
    int cnt;
    bit seen;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    x        = '0;
    y        = '0;
    b_in     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_bout", int'(b_out), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b0;

    op(4'b0111, 4'b0011, 1'b0, 0);
    op(4'b0011, 4'b0111, 1'b0, 0);
    op(4'b0000, 4'b0000, 1'b1, 0);
    op(4'b0111, 4'b1000, 1'b0, 0);
    op(4'b1000, 4'b0001, 1'b0, 0);

    // results hold between operations
    repeat (3) @(negedge clk);
    chk("hold_d", int'(d), 4'b0111);
    chk("hold_ovf", int'(ovf), 1);

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1;
    x     = W'($urandom);
    y     = W'($urandom);
    b_in  = 1'($urandom);
    sb.push_back(model(x, y, b_in));
    last = -1;
    for (int p = 0; p < 6; p++) begin
      seen = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (done) begin
          seen = 1;
          break;
        end
      end
      if (!seen) begin
        chk("b2b_timeout", 0, 1);
        break;
      end
      if (last >= 0)
        chk("b2b_period", cyc - last, W + 1);
      last = cyc;
      if (p < 5) begin
        x    = W'($urandom);
        y    = W'($urandom);
        b_in = 1'($urandom);
        sb.push_back(model(x, y, b_in));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;

    // reset in the second RUN cycle
    @(negedge clk);
    start = 1'b1;
    x     = 4'b0101;
    y     = 4'b0010;
    b_in  = 1'b0;
    sb.push_back(model(x, y, b_in));
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_d", int'(d), 0);
    chk("mid_rst_bout", int'(b_out), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("no_done_after_rst", cnt, 0);
    op(4'b1001, 4'b0110, 1'b1, 0);

    // exhaustive sweep
    for (int a = 0; a < 16; a++)
      for (int bb = 0; bb < 16; bb++)
        for (int bi = 0; bi < 2; bi++)
          op(W'(a), W'(bb), 1'(bi), 0);

    // random ops with noise during RUN
    for (int k = 0; k < 40; k++)
      op(W'($urandom), W'($urandom),
         1'($urandom), 1);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
